// File: rtl/zint_prio_if.sv
// Bus bundle for the zint_prio interrupt prioritiser.
// boost_start exists only when ZINT_BOOST_EN is defined.
interface zint_prio_if #(
  parameter int NSRC = 4
);
  logic            zpos;
  logic            wait_n;
  logic            vdos;
  logic            intack;
  logic [NSRC-1:0] int_start;
  logic [NSRC-1:0] intmask;
  logic [NSRC-1:0] pend;
  logic [7:0]      im2vect;
`ifdef ZINT_BOOST_EN
  logic            boost_start;
`endif

  modport slave (
    input  zpos, wait_n, vdos, intack, int_start, intmask,
    output pend, im2vect
`ifdef ZINT_BOOST_EN
    , output boost_start
`endif
  );

  modport master (
    output zpos, wait_n, vdos, intack, int_start, intmask,
    input  pend, im2vect
`ifdef ZINT_BOOST_EN
    , input boost_start
`endif
  );
endinterface

// File: rtl/zint_prio.sv
// Z80 IM2 interrupt prioritiser with pulse-limited sources and VDOS blocking.
// Optional feature macro: ZINT_BOOST_EN adds the boost_start strobe.
module zint_prio #(
  parameter int         NSRC       = 4,
  parameter logic [7:0] VECT_BASE  = 8'hFF,
  parameter logic [7:0] PULSE_MASK = 8'h01,
  parameter logic [7:0] DROP_MASK  = 8'h03,
  parameter int         PULSE_LEN  = 32
) (
  input  logic       clk,
  input  logic       res_n,
  zint_prio_if.slave bus,
  output wire        int_n
);

  if ((NSRC < 1) || (NSRC > 8)) begin : g_bad_nsrc
    $error("zint_prio: NSRC must be 1..8");
  end
  if (int'(VECT_BASE) < 2 * (NSRC - 1)) begin : g_bad_vect
    $error("zint_prio: VECT_BASE too small, vectors would wrap");
  end
  if ((PULSE_LEN < 1) || (PULSE_LEN > 255)) begin : g_bad_len
    $error("zint_prio: PULSE_LEN must be 1..255");
  end

  localparam logic [8:0] CNT_DONE = 9'(PULSE_LEN);

  logic [NSRC-1:0] pmask_s;
  logic [NSRC-1:0] dmask_s;
  logic            intack_q;
  logic            wait_q;
  logic [NSRC-1:0] pend_q;
  logic [NSRC-1:0] pend_d;
  logic [7:0]      im2vect_q;
  logic [7:0]      im2vect_d;
  logic [8:0]      cnt_q;
  logic [8:0]      cnt_d;
  logic            intack_s;
  logic            done_s;
  logic            load_s;
  logic [NSRC-1:0] accept_s;
  logic [NSRC-1:0] ack_clr_s;
  logic [NSRC-1:0] pulse_clr_s;
  logic [2:0]      win_idx_s;
  logic            win_hit_s;
  logic            ack_hit_s;

  assign pmask_s  = PULSE_MASK[NSRC-1:0];
  assign dmask_s  = DROP_MASK[NSRC-1:0];
  assign intack_s = bus.intack & ~intack_q;
  assign done_s   = (cnt_q == CNT_DONE);
  // A masked source never accepts; droppable sources lose their start under VDOS.
  assign accept_s = bus.int_start & bus.intmask & ~(dmask_s & {NSRC{bus.vdos}});
  assign load_s   = |(accept_s & pmask_s);

  // Lowest pending index wins the acknowledge.
  always_comb begin
    win_idx_s = 3'd0;
    win_hit_s = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      win_idx_s = pend_q[i] ? 3'(i) : win_idx_s;
      win_hit_s = pend_q[i] | win_hit_s;
    end
  end

  assign ack_hit_s = intack_s & win_hit_s;

  // Clear masks from acknowledge and pulse expiry, then next-state for pend/vector.
  always_comb begin
    ack_clr_s = '0;
    for (int i = 0; i < NSRC; i++) begin
      ack_clr_s[i] = ack_hit_s & (win_idx_s == 3'(i));
    end
    pulse_clr_s = done_s ? pmask_s : '0;
    pend_d      = ((pend_q & ~ack_clr_s & ~pulse_clr_s) | accept_s) & bus.intmask;
    if (ack_hit_s) begin
      im2vect_d = VECT_BASE - {4'b0000, win_idx_s, 1'b0};
    end else begin
      im2vect_d = im2vect_q;
    end
  end

  // Pulse counter: reload on a pulse-source start, count free zpos strobes, saturate.
  always_comb begin
    if (load_s) begin
      cnt_d = 9'd0;
    end else if (bus.zpos & ~done_s & ~wait_q & ~bus.vdos) begin
      cnt_d = cnt_q + 9'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      intack_q  <= 1'b0;
      wait_q    <= 1'b0;
      pend_q    <= '0;
      im2vect_q <= VECT_BASE;
      cnt_q     <= CNT_DONE;
    end else begin
      intack_q  <= bus.intack;
      wait_q    <= ~bus.wait_n;
      pend_q    <= pend_d;
      im2vect_q <= im2vect_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.pend    = pend_q;
  assign bus.im2vect = im2vect_q;
  // Open-drain request; released while VDOS owns the bus.
  assign int_n = ((|pend_q) & ~bus.vdos) ? 1'b0 : 1'bz;

`ifdef ZINT_BOOST_EN
  logic done_q;

  // Delayed done for expiry edge detection; resets high so release gives no pulse.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      done_q <= 1'b1;
    end else begin
      done_q <= done_s;
    end
  end

  assign bus.boost_start = res_n & (intack_s | (done_s & ~done_q));
`endif

endmodule

// File: tb/tb_zint_prio.sv
// Self-checking bench for zint_prio (NSRC=4, default parameters).
module tb_zint_prio;
  localparam int         NSRC = 4;
  localparam logic [7:0] VB   = 8'hFF;
  localparam logic [3:0] PM   = 4'b0001;
  localparam logic [3:0] DM   = 4'b0011;
  localparam int         PL   = 32;

  logic clk = 1'b0;
  logic res_n;
  wire  int_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  bit [3:0] m_pend;
  bit [7:0] m_vect;
  int       m_eff;
  bit       m_ack_prev;
  bit       m_wait_reg;

  pullup (int_n);

  zint_prio_if #(.NSRC(NSRC)) bus ();

  zint_prio #(.NSRC(NSRC)) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus.slave),
    .int_n (int_n)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pend = '0; m_vect = VB; m_eff = PL; m_ack_prev = 1'b0; m_wait_reg = 1'b0;
  endtask

  // Reference behaviour from the source rules, evaluated once per clock.
  task automatic model_step();
    bit [3:0] np;
    bit expired, pstart;
    int w;
    np = m_pend;
    expired = (m_eff >= PL);
    pstart = 1'b0;
    if (bus.intack && !m_ack_prev) begin
      w = -1;
      for (int i = NSRC - 1; i >= 0; i--) if (m_pend[i]) w = i;
      if (w >= 0) begin
        m_vect = 8'((int'(VB) - 2 * w) & 255);
        np[w] = 1'b0;
      end
    end
    for (int i = 0; i < NSRC; i++) begin
      if (expired && PM[i]) np[i] = 1'b0;
      if (bus.int_start[i] && bus.intmask[i] && !(DM[i] && bus.vdos)) begin
        np[i] = 1'b1;
        if (PM[i]) pstart = 1'b1;
      end
      if (!bus.intmask[i]) np[i] = 1'b0;
    end
    if (pstart) m_eff = 0;
    else if (bus.zpos && !expired && !m_wait_reg && !bus.vdos) m_eff++;
    m_pend = np;
    m_ack_prev = bus.intack;
    m_wait_reg = !bus.wait_n;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.zpos = 1'b0; bus.wait_n = 1'b1; bus.vdos = 1'b0; bus.intack = 1'b0;
    bus.int_start = 4'b0000; bus.intmask = 4'b1111;
  endtask

  task automatic test_reset();
    idle_inputs();
    res_n = 1'b0;
    bus.int_start = 4'b1111;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (bus.pend !== 4'b0000) $display("FAIL reset_pend: got %b want 0000", bus.pend); else pass_cnt++;
    total_cnt++; if (bus.im2vect !== 8'hFF) $display("FAIL reset_vect: got %h want ff", bus.im2vect); else pass_cnt++;
    total_cnt++; if (int_n !== 1'b1) $display("FAIL reset_int_n: got %b want released", int_n); else pass_cnt++;
    bus.int_start = 4'b0000;
    res_n = 1'b1;
  endtask

  task automatic test_dual_ack();
    bus.int_start = 4'b0101; tick(); bus.int_start = 4'b0000;
    total_cnt++; if (bus.pend !== 4'b0101) $display("FAIL dual_pend0: got %b want 0101", bus.pend); else pass_cnt++;
    total_cnt++; if (int_n !== 1'b0) $display("FAIL dual_int_n0: got %b want 0", int_n); else pass_cnt++;
    bus.intack = 1'b1; tick();
    total_cnt++; if (bus.im2vect !== 8'hFF || bus.pend !== 4'b0100) $display("FAIL dual_ack1: got %h/%b want ff/0100", bus.im2vect, bus.pend); else pass_cnt++;
    tick();
    total_cnt++; if (bus.pend !== 4'b0100) $display("FAIL dual_level_held: got %b want 0100", bus.pend); else pass_cnt++;
    bus.intack = 1'b0; tick();
    bus.intack = 1'b1; tick();
    total_cnt++; if (bus.im2vect !== 8'hFB || bus.pend !== 4'b0000) $display("FAIL dual_ack2: got %h/%b want fb/0000", bus.im2vect, bus.pend); else pass_cnt++;
    total_cnt++; if (int_n !== 1'b1) $display("FAIL dual_int_n2: got %b want released", int_n); else pass_cnt++;
    bus.intack = 1'b0; tick();
  endtask

  task automatic test_pulse_expiry();
    bit blocked;
    bus.int_start = 4'b0001; tick(); bus.int_start = 4'b0000;
    for (int k = 0; k < 37; k++) begin
      blocked = ((k % 7) == 3);
      bus.zpos = 1'b0; bus.wait_n = !blocked; tick();
      if (k == 36) begin
        total_cnt++; if (bus.pend !== 4'b0001) $display("FAIL pulse_early: got %b want 0001", bus.pend); else pass_cnt++;
      end
      bus.zpos = 1'b1; tick();
    end
    bus.zpos = 1'b0; bus.wait_n = 1'b1;
    total_cnt++; if (bus.pend !== 4'b0001) $display("FAIL pulse_at_done: got %b want 0001", bus.pend); else pass_cnt++;
    tick();
    total_cnt++; if (bus.pend !== 4'b0000) $display("FAIL pulse_expired: got %b want 0000", bus.pend); else pass_cnt++;
    total_cnt++; if (int_n !== 1'b1) $display("FAIL pulse_int_n: got %b want released", int_n); else pass_cnt++;
  endtask

  task automatic test_vdos();
    bus.vdos = 1'b1; bus.int_start = 4'b1010; tick(); bus.int_start = 4'b0000;
    total_cnt++; if (bus.pend !== 4'b1000) $display("FAIL vdos_pend: got %b want 1000", bus.pend); else pass_cnt++;
    total_cnt++; if (int_n !== 1'b1) $display("FAIL vdos_int_n: got %b want released", int_n); else pass_cnt++;
    bus.vdos = 1'b0; #1;
    total_cnt++; if (int_n !== 1'b0) $display("FAIL vdos_release: got %b want 0", int_n); else pass_cnt++;
    bus.intack = 1'b1; tick();
    total_cnt++; if (bus.im2vect !== 8'hF9 || bus.pend !== 4'b0000) $display("FAIL vdos_ack: got %h/%b want f9/0000", bus.im2vect, bus.pend); else pass_cnt++;
    bus.intack = 1'b0; tick();
  endtask

  task automatic test_mask();
    bus.int_start = 4'b0100; tick(); bus.int_start = 4'b0000;
    total_cnt++; if (bus.pend !== 4'b0100) $display("FAIL mask_set: got %b want 0100", bus.pend); else pass_cnt++;
    bus.intmask = 4'b1011; tick();
    total_cnt++; if (bus.pend !== 4'b0000) $display("FAIL mask_clear: got %b want 0000", bus.pend); else pass_cnt++;
    bus.int_start = 4'b0100; tick(); bus.int_start = 4'b0000;
    total_cnt++; if (bus.pend !== 4'b0000) $display("FAIL mask_ignore: got %b want 0000", bus.pend); else pass_cnt++;
    bus.intmask = 4'b1111; tick();
    total_cnt++; if (bus.pend !== 4'b0000) $display("FAIL mask_no_defer: got %b want 0000", bus.pend); else pass_cnt++;
  endtask

  task automatic test_ack_start_collision();
    bus.int_start = 4'b0010; tick();
    bus.intack = 1'b1; tick(); bus.int_start = 4'b0000;
    total_cnt++; if (bus.pend !== 4'b0010 || bus.im2vect !== 8'hFD) $display("FAIL collide: got %b/%h want 0010/fd", bus.pend, bus.im2vect); else pass_cnt++;
    bus.intack = 1'b0; tick();
    bus.intack = 1'b1; tick();
    total_cnt++; if (bus.pend !== 4'b0000) $display("FAIL collide_reack: got %b want 0000", bus.pend); else pass_cnt++;
    bus.intack = 1'b0; tick();
  endtask

  task automatic test_reset_abort();
    bus.int_start = 4'b0001; tick(); bus.int_start = 4'b0000;
    bus.zpos = 1'b1; bus.intack = 1'b1; tick(); tick();
    #2 res_n = 1'b0;
    #1;
    model_reset();
    total_cnt++; if (bus.pend !== 4'b0000 || bus.im2vect !== 8'hFF) $display("FAIL abort: got %b/%h want 0000/ff", bus.pend, bus.im2vect); else pass_cnt++;
    @(posedge clk); #1;
    bus.zpos = 1'b0; bus.intack = 1'b0;
    res_n = 1'b1;
  endtask

`ifdef ZINT_BOOST_EN
  task automatic test_boost();
    for (int k = 0; k < 3; k++) begin
      tick();
      total_cnt++; if (bus.boost_start !== 1'b0) $display("FAIL boost_after_reset: got %b want 0", bus.boost_start); else pass_cnt++;
    end
    bus.intack = 1'b1; #1;
    total_cnt++; if (bus.boost_start !== 1'b1) $display("FAIL boost_ack: got %b want 1", bus.boost_start); else pass_cnt++;
    tick();
    total_cnt++; if (bus.boost_start !== 1'b0) $display("FAIL boost_ack_len: got %b want 0", bus.boost_start); else pass_cnt++;
    bus.intack = 1'b0;
    bus.int_start = 4'b0001; tick(); bus.int_start = 4'b0000;
    bus.zpos = 1'b1;
    for (int k = 1; k <= PL; k++) begin
      tick();
      total_cnt++;
      if (bus.boost_start !== (k == PL)) $display("FAIL boost_expiry: step %0d got %b want %b", k, bus.boost_start, (k == PL));
      else pass_cnt++;
    end
    bus.zpos = 1'b0; tick();
    total_cnt++; if (bus.boost_start !== 1'b0) $display("FAIL boost_expiry_len: got %b want 0", bus.boost_start); else pass_cnt++;
  endtask
`endif

  task automatic test_random();
    bit exp_int_n;
    for (int n = 0; n < 1500; n++) begin
      bus.zpos      = $urandom_range(0, 1) == 0;
      bus.wait_n    = $urandom_range(0, 4) != 0;
      bus.vdos      = $urandom_range(0, 9) == 0;
      bus.intack    = $urandom_range(0, 3) == 0;
      bus.int_start = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      bus.intmask   = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'b1111;
      tick();
      exp_int_n = (m_pend != 4'b0000 && !bus.vdos) ? 1'b0 : 1'b1;
      total_cnt++; if (bus.pend !== m_pend) $display("FAIL rand_pend: cycle %0d got %b want %b", n, bus.pend, m_pend); else pass_cnt++;
      total_cnt++; if (bus.im2vect !== m_vect) $display("FAIL rand_vect: cycle %0d got %h want %h", n, bus.im2vect, m_vect); else pass_cnt++;
      total_cnt++; if (int_n !== exp_int_n) $display("FAIL rand_int_n: cycle %0d got %b want %b", n, int_n, exp_int_n); else pass_cnt++;
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_dual_ack();
    test_pulse_expiry();
    test_vdos();
    test_mask();
    test_ack_start_collision();
    test_reset_abort();
`ifdef ZINT_BOOST_EN
    test_boost();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
